// File: rtl/vreg_wb_arbiter_if.sv
// Writeback request, scoreboard and register-file write bundle for the vector writeback arbiter.
// The design takes the slave modport and the requesters/environment take the master modport.
interface vreg_wb_arbiter_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 256;

  logic          alu_valid;
  logic [AW-1:0] alu_wa;
  logic [DW-1:0] alu_wd;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic          mem_ready;
  logic          iss_valid;
  logic [AW-1:0] iss_wa;
  logic [AW-1:0] chk_ra1;
  logic [AW-1:0] chk_ra2;
  logic          hazard;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          drop_err;

  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
           iss_valid, iss_wa, chk_ra1, chk_ra2,
    output alu_ready, mem_ready, hazard, rf_we, rf_wa, rf_wd, drop_err
  );

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
           iss_valid, iss_wa, chk_ra1, chk_ra2,
    input  alu_ready, mem_ready, hazard, rf_we, rf_wa, rf_wd, drop_err
  );
endinterface

// File: rtl/vreg_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter with a registered write stage and a pending-write
// scoreboard for issue-stage hazard detection. Register 7 is a read-only alternate source.
module vreg_wb_arbiter (
  input  logic            clk,
  input  logic            reset,
  vreg_wb_arbiter_if.slave bus
);
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 256;
  localparam int unsigned NREG  = 8;
  localparam logic [AW-1:0] RO_REG = AW'(7);

  // Pointer: 0 favours ALU, 1 favours MEM
  logic            ptr;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            grant_alu;
  logic            grant_mem;
  logic            xfer;
  logic [AW-1:0]   sel_wa;
  logic [DW-1:0]   sel_wd;
  logic            haz1;
  logic            haz2;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      grant_alu = bus.alu_valid && (!bus.mem_valid || !ptr);
      grant_mem = bus.mem_valid && (!bus.alu_valid ||  ptr);
    end
    xfer   = grant_alu || grant_mem;
    sel_wa = grant_mem ? bus.mem_wa : bus.alu_wa;
    sel_wd = grant_mem ? bus.mem_wd : bus.alu_wd;
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  // Retiring write clears first so a same-edge issue mark of that register survives
  always_comb begin
    pending_nxt = pending;
    if (bus.rf_we) pending_nxt[bus.rf_wa] = 1'b0;
    if (bus.iss_valid && (bus.iss_wa != RO_REG)) pending_nxt[bus.iss_wa] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= 1'b0;
      pending      <= '0;
      bus.rf_we    <= 1'b0;
      bus.drop_err <= 1'b0;
      bus.rf_wa    <= '0;
      bus.rf_wd    <= '0;
    end else begin
      if (xfer) ptr <= grant_alu;
      pending      <= pending_nxt;
      bus.rf_we    <= xfer && (sel_wa != RO_REG);
      bus.drop_err <= xfer && (sel_wa == RO_REG);
      if (xfer && (sel_wa != RO_REG)) begin
        bus.rf_wa <= sel_wa;
        bus.rf_wd <= sel_wd;
      end
    end
  end

  assign haz1       = (bus.chk_ra1 != RO_REG) && pending[bus.chk_ra1];
  assign haz2       = (bus.chk_ra2 != RO_REG) && pending[bus.chk_ra2];
  assign bus.hazard = haz1 || haz2;
endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Bench for vreg_wb_arbiter: directed scenarios plus random traffic against a cycle-level
// reference model of grants, the write stage and the pending-register set.
module tb_vreg_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  vreg_wb_arbiter_if bus();

  vreg_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (as seen after the most recent rising edge)
  bit           m_favour_mem;
  bit           m_pend [8];
  bit           m_we;
  bit           m_drop;
  bit [2:0]     m_wa;
  bit [255:0]   m_wd;
  logic         obs_alu_ready;
  logic         obs_mem_ready;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_favour_mem = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we   = 1'b0;
    m_drop = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model
  task automatic step(input bit rst, input bit av, input bit [2:0] aw, input bit [255:0] ad,
                      input bit mv, input bit [2:0] mw, input bit [255:0] md,
                      input bit iv, input bit [2:0] iw, input bit [2:0] c1, input bit [2:0] c2);
    bit exp_ar, exp_mr, exp_haz, xfer;
    bit [2:0] gw;
    bit [255:0] gd;
    @(negedge clk);
    reset = rst;
    bus.alu_valid = av; bus.alu_wa = aw; bus.alu_wd = ad;
    bus.mem_valid = mv; bus.mem_wa = mw; bus.mem_wd = md;
    bus.iss_valid = iv; bus.iss_wa = iw;
    bus.chk_ra1 = c1;   bus.chk_ra2 = c2;
    #1;
    if (rst) begin
      exp_ar = 1'b0; exp_mr = 1'b0;
    end else if (av && mv) begin
      exp_ar = !m_favour_mem; exp_mr = m_favour_mem;
    end else begin
      exp_ar = av; exp_mr = mv;
    end
    exp_haz = (c1 != 3'd7 && m_pend[c1]) || (c2 != 3'd7 && m_pend[c2]);
    obs_alu_ready = bus.alu_ready;
    obs_mem_ready = bus.mem_ready;
    chk("alu_ready", 256'(bus.alu_ready), 256'(exp_ar));
    chk("mem_ready", 256'(bus.mem_ready), 256'(exp_mr));
    chk("hazard",    256'(bus.hazard),    256'(exp_haz));
    chk("rf_we",     256'(bus.rf_we),     256'(m_we));
    chk("drop_err",  256'(bus.drop_err),  256'(m_drop));
    chk("rf_wa",     256'(bus.rf_wa),     256'(m_wa));
    chk("rf_wd",     bus.rf_wd,           m_wd);
    if (rst) begin
      model_reset();
    end else begin
      xfer = exp_ar || exp_mr;
      gw = exp_mr ? mw : aw;
      gd = exp_mr ? md : ad;
      if (m_we) m_pend[m_wa] = 1'b0;
      if (iv && iw != 3'd7) m_pend[iw] = 1'b1;
      if (xfer) m_favour_mem = exp_ar;
      m_we   = xfer && gw != 3'd7;
      m_drop = xfer && gw == 3'd7;
      if (m_we) begin
        m_wa = gw; m_wd = gd;
      end
    end
  endtask

  function automatic bit [255:0] rnd_wd();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  localparam bit [255:0] PAT_A5 = {32{8'hA5}};

  initial begin
    model_reset();
    reset = 1'b1;
    bus.alu_valid = 0; bus.alu_wa = 0; bus.alu_wd = 0;
    bus.mem_valid = 0; bus.mem_wa = 0; bus.mem_wd = 0;
    bus.iss_valid = 0; bus.iss_wa = 0; bus.chk_ra1 = 0; bus.chk_ra2 = 0;

    // Reset, with requests and issue marks that must all be ignored
    step(1, 1, 3'd1, PAT_A5, 1, 3'd2, PAT_A5, 1, 3'd4, 3'd4, 3'd0);
    step(1, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd4, 3'd0);

    // Single ALU write to v3
    step(0, 1, 3'd3, PAT_A5, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd0);
    chk("single_alu_grant", 256'(obs_alu_ready), 256'(1));
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd0);
    chk("single_alu_wd", bus.rf_wd, PAT_A5);
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd0);

    // Dual contention right after reset: ALU, MEM, ALU, MEM
    step(1, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 3'(i), rnd_wd(), 1, 3'(i + 4) & 3'd5, rnd_wd(), 0, 3'd0, 3'd0, 3'd0);
      chk("rr_order_alu", 256'(obs_alu_ready), 256'((i % 2) == 0));
    end
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd0);

    // Pending v5 cleared by a load writeback
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 1, 3'd5, 3'd5, 3'd0);
    step(0, 0, 3'd0, '0, 1, 3'd5, rnd_wd(), 0, 3'd0, 3'd5, 3'd0);
    chk("haz_v5_set", 256'(bus.hazard), 256'(1));
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd5, 3'd0);
    chk("haz_v5_during_we", 256'(bus.hazard), 256'(1));
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd5, 3'd0);
    chk("haz_v5_cleared", 256'(bus.hazard), 256'(0));

    // Same-edge mark and retire of v2: mark wins
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 1, 3'd2, 3'd0, 3'd2);
    step(0, 1, 3'd2, rnd_wd(), 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd2);
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 1, 3'd2, 3'd0, 3'd2);
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd2);
    chk("set_wins_v2", 256'(bus.hazard), 256'(1));

    // Writes and marks of v7 are discarded
    step(0, 1, 3'd7, rnd_wd(), 0, 3'd0, '0, 1, 3'd7, 3'd7, 3'd7);
    chk("v7_accepted", 256'(obs_alu_ready), 256'(1));
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd7, 3'd7);
    chk("v7_drop_err", 256'(bus.drop_err), 256'(1));
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd7, 3'd7);

    // Reset the edge after a transfer: write discarded, pointer back to ALU
    step(0, 0, 3'd0, '0, 1, 3'd1, rnd_wd(), 0, 3'd0, 3'd0, 3'd0);
    step(1, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd2, 3'd0);
    step(0, 1, 3'd3, rnd_wd(), 1, 3'd4, rnd_wd(), 0, 3'd0, 3'd2, 3'd0);
    chk("post_reset_alu_first", 256'(obs_alu_ready), 256'(1));
    step(0, 0, 3'd0, '0, 0, 3'd0, '0, 0, 3'd0, 3'd0, 3'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 3'($urandom()), rnd_wd(),
           ($urandom_range(0, 3) != 0), 3'($urandom()), rnd_wd(),
           ($urandom_range(0, 1) == 0), 3'($urandom()), 3'($urandom()), 3'($urandom()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vreg_wb_arbiter.md
VREG_WB_ARBITER -- requirements
Module: vreg_wb_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 SHALL provide these ports (name  direction  width  meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_wa  in  3  ALU destination vector register.
- alu_wd  in  256  ALU writeback data.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load-unit writeback request.
- mem_wa  in  3  load-unit destination vector register.
- mem_wd  in  256  load-unit writeback data.
- mem_ready  out  1  load-unit request accepted this cycle.
- iss_valid  in  1  issue stage marks a destination as pending.
- iss_wa  in  3  destination being marked.
- chk_ra1  in  3  issue-stage source register 1 to check.
- chk_ra2  in  3  issue-stage source register 2 to check.
- hazard  out  1  a checked source has a pending write.
- rf_we  out  1  register-file write enable.
- rf_wa  out  3  register-file write address.
- rf_wd  out  256  register-file write data.
- drop_err  out  1  accepted write to register 7 was discarded.

Function
REQ-003 SHALL accept at most one request per cycle; a transfer occurs when valid and ready are both high at a rising edge.
REQ-004 SHALL compute ready combinationally from the valid inputs and the priority pointer; ready SHALL never be high while its valid is low, and alu_ready and mem_ready SHALL never both be high.
REQ-005 Single requester valid: that requester SHALL be granted, regardless of the pointer.
REQ-006 Both requesters valid: the pointer side SHALL be granted.
REQ-007 After every transfer, the pointer SHALL point to the non-granted side (round-robin); with no transfer it SHALL hold.
REQ-008 Output stage registered: a transfer at edge N SHALL drive rf_we=1 with rf_wa/rf_wd equal to the granted wa/wd for exactly cycle N+1; the register file commits it on the falling edge within that cycle.
REQ-009 Without a transfer, rf_we SHALL be 0 the next cycle; rf_wa/rf_wd SHALL hold their last values.
REQ-010 A transfer with wa=7 SHALL be accepted (ready high) but SHALL NOT assert rf_we; drop_err SHALL pulse 1 for cycle N+1 instead. Register 7 reads return a fixed alternate source and are not writable.
REQ-011 The scoreboard SHALL be an 8-bit pending vector.
REQ-012 iss_valid with iss_wa!=7 SHALL set pending[iss_wa] at the edge; iss_wa=7 SHALL be ignored.
REQ-013 A cycle with rf_we=1 SHALL clear pending[rf_wa] at the end of that cycle, so hazard deasserts no earlier than cycle N+2 after the transfer edge N.
REQ-014 Same-edge set and clear of the same register: set SHALL win; set and clear of different registers SHALL both take effect.
REQ-015 hazard SHALL equal pending[chk_ra1] OR pending[chk_ra2], combinational from registered state; checks of register 7 SHALL contribute 0.
REQ-016 Sustained back-to-back traffic SHALL give one write per cycle with no bubbles; under dual contention, grants SHALL alternate strictly.

Reset
REQ-017 While reset=1, alu_ready and mem_ready SHALL be 0.
REQ-018 At a reset edge, rf_we SHALL clear to 0, drop_err to 0, rf_wa to 0, rf_wd to 0, all pending bits to 0, and the pointer to ALU; hazard SHALL read 0 the following cycle.
REQ-019 A transfer captured in the output stage when reset asserts SHALL be discarded (no rf_we in the cycle after the reset edge).
REQ-020 iss_valid SHALL be ignored during reset.

Verification
REQ-021 Single ALU request, wa=3, wd=0xA5 repeated -> alu_ready=1 same cycle; rf_we=1, rf_wa=3, rf_wd=0xA5.. next cycle; rf_we=0 after.
REQ-022 Both valid for 4 cycles after reset, distinct wa -> grant order ALU, MEM, ALU, MEM; four consecutive rf_we pulses, no bubbles.
REQ-023 iss_valid wa=5, then chk_ra1=5 -> hazard=1; MEM write to 5 -> hazard stays 1 through the rf_we cycle and reads 0 the cycle after.
REQ-024 Same edge: iss_valid wa=2 and rf_we=1 with rf_wa=2 -> pending[2] remains 1, hazard=1 for chk_ra2=2.
REQ-025 ALU request wa=7 -> alu_ready=1, rf_we stays 0, drop_err=1 for one cycle; iss_valid wa=7 -> hazard stays 0 for chk 7.
REQ-026 Reset asserted the edge after a transfer -> no rf_we, pending cleared, pointer ALU (next dual request grants ALU).
